// File: rtl/wb_writer.sv
// Write-back sequencer: queues load and ALU/link results in program order and retires one per
// cycle into the register file write port. Optional same-cycle bypass via `WB_BYPASS_EN.
module wb_writer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     LdValid,
  output logic                     LdReady,
  input  logic [4:0]               LdRegNum,
  input  logic [31:0]              LdData,
  input  logic                     AluValid,
  output logic                     AluReady,
  input  logic [4:0]               AluRegNum,
  input  logic [31:0]              AluData,
  input  logic                     AluJal,
  output logic [31:0]              WbData,
  output logic [4:0]               WbRegNum,
  output logic                     RegWrite,
  input  logic [4:0]               R1Num,
  input  logic [4:0]               R2Num,
  output logic                     Pend1,
  output logic                     Pend2,
  output logic [31:0]              Fwd1,
  output logic [31:0]              Fwd2,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    reg_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          ld_acc, alu_acc, pop;
  logic [4:0]    alu_reg, first_r, enq0_r, enq1_r, wb_r;
  logic [31:0]   first_d, enq0_d, enq1_d, wb_d;
  logic          enq0_v, enq1_v;
  logic [1:0]    n_push;

  // Readiness uses start-of-cycle occupancy; a same-cycle pop does not free a slot.
  always_comb begin
    LdReady  = (count_q != CW'(DEPTH));
    AluReady = LdValid ? (count_q < CW'(DEPTH - 1)) : LdReady;
    ld_acc   = LdValid && LdReady;
    alu_acc  = AluValid && AluReady;
    alu_reg  = AluJal ? 5'd31 : AluRegNum;
    pop      = (count_q != '0);
  end

  always_comb begin
    first_r = ld_acc ? LdRegNum : alu_reg;
    first_d = ld_acc ? LdData : AluData;
    enq0_v  = ld_acc || alu_acc;
    enq0_r  = first_r;
    enq0_d  = first_d;
    enq1_v  = ld_acc && alu_acc;
    enq1_r  = alu_reg;
    enq1_d  = AluData;
    wb_r    = '0;
    wb_d    = '0;
    if (pop) begin
      wb_r = reg_mem[rd_ptr_q];
      wb_d = dat_mem[rd_ptr_q];
    end
`ifdef WB_BYPASS_EN
    else if (enq0_v) begin
      // Oldest accept goes straight to the port; any second accept takes the first slot.
      wb_r   = first_r;
      wb_d   = first_d;
      enq0_v = enq1_v;
      enq0_r = enq1_r;
      enq0_d = enq1_d;
      enq1_v = 1'b0;
    end
`endif
    n_push = {1'b0, enq0_v} + {1'b0, enq1_v};
  end

  assign WbRegNum = wb_r;
  assign WbData   = wb_d;
  assign RegWrite = (wb_r != 5'd0);
  assign Count    = count_q;

  always_ff @(posedge clk) begin
    if (enq0_v) begin
      reg_mem[wr_ptr_q] <= enq0_r;
      dat_mem[wr_ptr_q] <= enq0_d;
    end
    if (enq1_v) begin
      reg_mem[wr_ptr_q + AW'(1)] <= enq1_r;
      dat_mem[wr_ptr_q + AW'(1)] <= enq1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      count_q  <= count_q + CW'(n_push) - CW'(pop);
    end
  end

  // Scan oldest to youngest so the last hit is the youngest match.
  function automatic logic [32:0] lookup(input logic [4:0] rn);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (reg_mem[idx] == rn) && (rn != 5'd0)) begin
        res = {1'b1, dat_mem[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {Pend1, Fwd1} = lookup(R1Num);
    {Pend2, Fwd2} = lookup(R2Num);
  end

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: a queue model of the FIFO acts as the scoreboard, plus
// table-driven single-result vectors and hand-written multi-cycle sequences.
module tb_wb_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          LdValid, LdReady, AluValid, AluReady, AluJal, RegWrite, Pend1, Pend2;
  logic [4:0]    LdRegNum, AluRegNum, WbRegNum, R1Num, R2Num;
  logic [31:0]   LdData, AluData, WbData, Fwd1, Fwd2;
  logic [CW-1:0] Count;

  wb_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .LdValid(LdValid), .LdReady(LdReady), .LdRegNum(LdRegNum), .LdData(LdData),
    .AluValid(AluValid), .AluReady(AluReady), .AluRegNum(AluRegNum), .AluData(AluData),
    .AluJal(AluJal), .WbData(WbData), .WbRegNum(WbRegNum), .RegWrite(RegWrite),
    .R1Num(R1Num), .R2Num(R2Num), .Pend1(Pend1), .Pend2(Pend2), .Fwd1(Fwd1), .Fwd2(Fwd2),
    .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        ldv;
    logic [4:0]  ldr;
    logic [31:0] ldd;
    logic        aluv;
    logic [4:0]  alur;
    logic [31:0] alud;
    logic        jal;
    logic [4:0]  r1;
    logic [4:0]  exp_r;
    logic [31:0] exp_d;
    logic        exp_we;
    logic        exp_p1;
    logic [31:0] exp_f1;
  } vec_t;

  ent_t mq[$];
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  logic lacc_q, aacc_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ldv, input logic [4:0] ldr, input logic [31:0] ldd,
                       input logic aluv, input logic [4:0] alur, input logic [31:0] alud,
                       input logic jal);
    LdValid = ldv;  LdRegNum = ldr;   LdData = ldd;
    AluValid = aluv; AluRegNum = alur; AluData = alud; AluJal = jal;
  endtask

  task automatic idle();
    LdValid = 1'b0;
    AluValid = 1'b0;
    AluJal = 1'b0;
  endtask

  // One clock: check all outputs against the queue model, then advance the model at the edge.
  task automatic step();
    int          n;
    logic        exp_ldr, exp_alur, p1, p2, skip;
    logic [4:0]  ar, wr;
    logic [31:0] wd, f1, f2;
    #1;
    n        = mq.size();
    exp_ldr  = (n <= DEPTH - 1);
    exp_alur = LdValid ? (n <= DEPTH - 2) : exp_ldr;
    lacc_q   = LdValid && exp_ldr;
    aacc_q   = AluValid && exp_alur;
    ar       = AluJal ? 5'd31 : AluRegNum;
    wr = '0;
    wd = '0;
    if (n > 0) begin
      wr = mq[0].r;
      wd = mq[0].d;
    end
`ifdef WB_BYPASS_EN
    else if (lacc_q) begin
      wr = LdRegNum;
      wd = LdData;
    end else if (aacc_q) begin
      wr = ar;
      wd = AluData;
    end
`endif
    p1 = 1'b0; f1 = '0; p2 = 1'b0; f2 = '0;
    foreach (mq[i]) begin
      if (mq[i].r == R1Num && R1Num != 5'd0) begin p1 = 1'b1; f1 = mq[i].d; end
      if (mq[i].r == R2Num && R2Num != 5'd0) begin p2 = 1'b1; f2 = mq[i].d; end
    end
    chk("LdReady", LdReady, exp_ldr);
    chk("AluReady", AluReady, exp_alur);
    chk("Count", Count, n);
    chk("WbRegNum", WbRegNum, wr);
    chk("WbData", WbData, wd);
    chk("RegWrite", RegWrite, wr != 5'd0);
    chk("Pend1", Pend1, p1);
    chk("Fwd1", Fwd1, f1);
    chk("Pend2", Pend2, p2);
    chk("Fwd2", Fwd2, f2);
    @(posedge clk);
    if (n > 0) begin
      void'(mq.pop_front());
      retired++;
    end
    skip = 1'b0;
`ifdef WB_BYPASS_EN
    skip = (n == 0);
    if (skip && (lacc_q || aacc_q)) retired++;
`endif
    if (lacc_q) begin
      if (skip) skip = 1'b0;
      else mq.push_back('{LdRegNum, LdData});
    end
    if (aacc_q) begin
      if (skip) skip = 1'b0;
      else mq.push_back('{ar, AluData});
    end
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 3 * DEPTH + 4 && mq.size() > 0; k++) step();
    chk(name, mq.size(), 0);
  endtask

  task automatic tabcheck(input vec_t v);
    chk("tab WbRegNum", WbRegNum, v.exp_r);
    chk("tab WbData", WbData, v.exp_d);
    chk("tab RegWrite", RegWrite, v.exp_we);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[5];
    int   ld_sent, alu_sent, seq;

    tab[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,
               5'd5,  32'h12345678, 1'b1, 1'b1, 32'h12345678};
    tab[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h400,      1'b1, 5'd7,
               5'd31, 32'h400,      1'b1, 1'b0, 32'h0};
    tab[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,
               5'd0,  32'hFFFF,     1'b0, 1'b0, 32'h0};
    tab[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd12,
               5'd12, 32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D};
    tab[4] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd31,
               5'd31, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF};

    // Reset held with a load offered: nothing may be accepted or written.
    rst_n = 1'b0;
    R1Num = '0;
    R2Num = '0;
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("rst RegWrite", RegWrite, 1'b0);
      chk("rst Count", Count, 0);
      chk("rst LdReady", LdReady, 1'b1);
      chk("rst AluReady", AluReady, 1'b1);
      chk("rst Pend1", Pend1, 1'b0);
      chk("rst WbData", WbData, 0);
    end
    rst_n = 1'b1;
    step();
    idle();
    step();
    chk("rst first accept retired", retired, 1);

    // Single-result vectors into an empty queue.
    for (int i = 0; i < 5; i++) begin
      R1Num = tab[i].r1;
      drive(tab[i].ldv, tab[i].ldr, tab[i].ldd, tab[i].aluv, tab[i].alur, tab[i].alud,
            tab[i].jal);
`ifdef WB_BYPASS_EN
      #1;
      tabcheck(tab[i]);
`endif
      step();
      idle();
`ifndef WB_BYPASS_EN
      tabcheck(tab[i]);
      chk("tab Pend1", Pend1, tab[i].exp_p1);
      chk("tab Fwd1", Fwd1, tab[i].exp_f1);
`endif
      step();
      chk("tab drained Count", Count, 0);
    end

    // Dual accept to the same register: load retires first, lookup sees the younger ALU value.
    R1Num = 5'd3;
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0);
    step();
    idle();
`ifndef WB_BYPASS_EN
    chk("dual first WbData", WbData, 32'hA);
    chk("dual Pend1", Pend1, 1'b1);
    chk("dual Fwd1", Fwd1, 32'hB);
`endif
    step();
    chk("dual second WbData", WbData, 32'hB);
    chk("dual second WbRegNum", WbRegNum, 5'd3);
    drain("dual drain");

    // Both producers always offering: exercises full/refill and pointer wrap.
    retired = 0;
    ld_sent = 0;
    alu_sent = 0;
    seq = 32'h1000;
    drive(1'b1, 5'($urandom_range(0, 31)), seq, 1'b1, 5'($urandom_range(0, 31)), seq + 1,
          1'($urandom_range(0, 1)));
    seq += 2;
    for (int cyc = 0; cyc < 400 && (ld_sent < 50 || alu_sent < 50); cyc++) begin
      R1Num = 5'($urandom_range(0, 31));
      R2Num = WbRegNum;
      step();
      if (lacc_q) begin
        ld_sent++;
        LdValid = (ld_sent < 50);
        LdRegNum = 5'($urandom_range(0, 31));
        LdData = seq;
        seq++;
      end
      if (aacc_q) begin
        alu_sent++;
        AluValid = (alu_sent < 50);
        AluRegNum = 5'($urandom_range(0, 31));
        AluData = seq;
        AluJal = 1'($urandom_range(0, 3) == 0);
        seq++;
      end
    end
    chk("fill sent", ld_sent + alu_sent, 100);
    idle();
    drain("fill drain");
    chk("fill retired", retired, 100);

    // Reset mid-drain discards queued entries.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0);
    step();
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst Count", Count, 0);
    chk("midrst RegWrite", RegWrite, 1'b0);
    mq.delete();
    #2;
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
# wb_writer

Write-back sequencer that feeds the single write port of the register file (`WbData`/`WbRegNum`/`RegWrite`). It sits at the end of the pipeline and accepts completed results from two producers: the load path (MEM stage) and the ALU/link path (EX stage). Results are queued in program order in a small FIFO and retired one per cycle. A pending/forwarding lookup lets decode detect and bypass results that have not yet been written.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `LdValid` in 1: load result offered.
- `LdReady` out 1: load result accepted this cycle.
- `LdRegNum` in 5: load destination register.
- `LdData` in 32: load data.
- `AluValid` in 1: ALU/link result offered.
- `AluReady` out 1: ALU result accepted this cycle.
- `AluRegNum` in 5: ALU destination; ignored when `AluJal`=1.
- `AluData` in 32: ALU result, or link address when `AluJal`=1.
- `AluJal` in 1: link write; destination is forced to 31.
- `WbData` out 32: register file write data.
- `WbRegNum` out 5: register file write index.
- `RegWrite` out 1: register file write enable.
- `R1Num`, `R2Num` in 5: decode source registers to look up.
- `Pend1`, `Pend2` out 1: the source has a queued, unretired write.
- `Fwd1`, `Fwd2` out 32: data of the youngest matching queued entry; 0 when not pending.
- `Count` out $clog2(DEPTH)+1: occupancy.

## Operation
- Entry = {regnum[4:0], data[31:0]}, stored in a circular buffer with `rd_ptr`, `wr_ptr` and `count`.
- Acceptance is computed from `count` at the start of the cycle; the same-cycle pop is not credited.
  - `LdReady` = (count ≤ DEPTH-1).
  - `AluReady` = (count ≤ DEPTH-2) if `LdValid` else (count ≤ DEPTH-1).
- Ordering: load is older than ALU, so on a dual accept the load is enqueued first.
- Retire: when count>0, the head is presented on `WbRegNum`/`WbData` and popped at the next edge. The register file always accepts, so there is no backpressure on the output.
- `RegWrite` = (count>0) && (head.regnum≠0). Writes to r0 still occupy a slot and retire with `RegWrite`=0.
- Lookup: compare `R1Num`/`R2Num` against all valid entries, including the head.
  - A match on r0 never asserts `PendN`.
  - With several matches, the youngest (closest to `wr_ptr`) supplies `FwdN`.
  - Lookup is purely combinational and does not include the entries being accepted this cycle.
- Reset (async assert): pointers and count go to 0.
  - Outputs: `RegWrite`=0, `WbRegNum`=0, `WbData`=0, `Pend*`=0, `Fwd*`=0, `Count`=0.
  - `LdReady`=1; `AluReady`=1 (DEPTH≥2).
  - Queued contents are discarded; a reset mid-drain loses unretired writes by design.

## Timing
- Latency without bypass: accepted at edge N, `RegWrite` high during cycle N+1, register written at edge N+1.
- Throughput: 1 retire/cycle; up to 2 enqueues/cycle.
- Simultaneous push and pop: count changes by pushes−1, and the pointers wrap modulo DEPTH.
- Full: `LdReady`=`AluReady`=0. The cycle after a pop, both refill per the rules above.
- Data/regnum must be stable while valid is high and ready is low. A producer may drop valid without a handshake.

## Configuration
- `WB_BYPASS_EN` defined: when count=0, the oldest result accepted this cycle drives `WbData`/`WbRegNum`/`RegWrite` combinationally and is written at edge N without being enqueued. A second simultaneous accept is enqueued normally. This gives 0-cycle latency into an empty queue.
- Not defined: every result is enqueued first, so the minimum latency is 1 cycle. No combinational path from `*Valid`/`*Data` to the `Wb*` outputs.

## Test plan
- Reset: hold `rst_n`=0 with `LdValid`=1, then release. Required: `RegWrite`=0 throughout reset, `Count`=0, `LdReady`=1; the first accept occurs at the first edge after release.
- Single load r5=0x12345678 into an empty queue. Required: `RegWrite`=1, `WbRegNum`=5, `WbData`=0x12345678 in the next cycle, or in the same cycle with `WB_BYPASS_EN`; `Count` then returns to 0.
- Dual accept of load r3=0xA and ALU r3=0xB in the same cycle. Required: retire order r3←0xA then r3←0xB; during the first retire cycle `Pend1`=1 and `Fwd1`=0xB for `R1Num`=3.
- `AluJal`=1 with `AluRegNum`=7 and `AluData`=0x400. Required: retires as `WbRegNum`=31, `WbData`=0x400.
- Fill with DEPTH=4, both valid every cycle. Required: `AluReady`=0 when count≥3, `LdReady`=0 at count=4; steady state is 1 accept per cycle; no entry lost or duplicated over 100 random results.
- ALU write to r0 with data 0xFFFF and lookup `R1Num`=0. Required: the slot retires with `RegWrite`=0, `Pend1`=0, `Fwd1`=0.
